// File: rtl/dp_pkg.sv
// Shared widths, FSM encoding and element extraction for the dot-product sequencer.
package dp_pkg;
    localparam int ELEM_W = 8;
    localparam int N_ELEM = 4;
    localparam int OUT_W  = 16;
    localparam int ACC_W  = 18;
    localparam int IDX_W  = $clog2(N_ELEM);
    localparam int VEC_W  = N_ELEM * ELEM_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [ELEM_W-1:0] elem(input logic [VEC_W-1:0] vec,
                                               input logic [IDX_W-1:0] i);
        return vec[ELEM_W*i +: ELEM_W];
    endfunction
endpackage

// File: rtl/dot_product_sequencer_if.sv
// Start/done handshake, operand vectors and held result for the dot-product sequencer.
interface dot_product_sequencer_if;
    import dp_pkg::*;
    logic             start;
    logic [VEC_W-1:0] A;
    logic [VEC_W-1:0] B;
    logic             busy;
    logic             done;
    logic             result_valid;
    logic [OUT_W-1:0] dot_product;
    logic             oflow;

    modport master (output start, A, B,
                    input  busy, done, result_valid, dot_product, oflow);
    modport slave  (input  start, A, B,
                    output busy, done, result_valid, dot_product, oflow);
endinterface

// File: rtl/dp_mac_stage.sv
// Two-stage multiply/accumulate: registered product, then accumulate when the product is valid.
module dp_mac_stage
    import dp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [ELEM_W-1:0]   a,
    input  logic [ELEM_W-1:0]   b,
    output logic [2*ELEM_W-1:0] prod,
    output logic [ACC_W-1:0]    acc
);
    logic pv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod <= '0;
            pv   <= 1'b0;
            acc  <= '0;
        end else if (clr) begin
            prod <= '0;
            pv   <= 1'b0;
            acc  <= '0;
        end else if (en) begin
            prod <= (2*ELEM_W)'(a) * (2*ELEM_W)'(b);
            pv   <= 1'b1;
            if (pv) acc <= acc + ACC_W'(prod);
        end
    end
endmodule

// File: rtl/dot_product_sequencer.sv
// Captures A/B on a start rising edge, runs the serial MAC, and holds the 16-bit result and overflow.
module dot_product_sequencer
    import dp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    dot_product_sequencer_if.slave  bus
);
    state_t             state, state_nxt;
    logic               start_q, armed, req;
    logic [VEC_W-1:0]   a_cap, b_cap;
    logic [IDX_W-1:0]   idx;
    logic [2*ELEM_W-1:0] prod;
    logic [ACC_W-1:0]   acc, acc_final;
    logic               busy, done, result_valid, oflow;
    logic [OUT_W-1:0]   dot_product;

    // armed stays low for the first edge after reset so a start held through reset never fires
    assign req       = bus.start & ~start_q & armed;
    assign acc_final = acc + ACC_W'(prod);

    dp_mac_stage u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE && req),
        .en   (state == MAC),
        .a    (elem(a_cap, idx)),
        .b    (elem(b_cap, idx)),
        .prod (prod),
        .acc  (acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = MAC;
            MAC:     if (idx == IDX_W'(N_ELEM-1)) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q      <= 1'b0;
            armed        <= 1'b0;
            a_cap        <= '0;
            b_cap        <= '0;
            idx          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            oflow        <= 1'b0;
            dot_product  <= '0;
        end else begin
            start_q <= bus.start;
            armed   <= 1'b1;
            case (state)
                IDLE: if (req) begin
                    a_cap        <= bus.A;
                    b_cap        <= bus.B;
                    idx          <= '0;
                    busy         <= 1'b1;
                    result_valid <= 1'b0;
                end
                MAC:   idx <= idx + 1'b1;
                DRAIN: begin
                    dot_product  <= acc_final[OUT_W-1:0];
                    oflow        <= |acc_final[ACC_W-1:OUT_W];
                    done         <= 1'b1;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                end
                DONE:    done <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.result_valid = result_valid;
    assign bus.dot_product  = dot_product;
    assign bus.oflow        = oflow;
endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: directed table, corner sequences and random ops against a sum model.
module tb_dot_product_sequencer;
    import dp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    dot_product_sequencer_if bus();
    dot_product_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] dp;
        logic        of;
    } vec_t;

    typedef struct {
        logic [15:0] dp;
        logic        of;
        logic        rv;
        logic        done_after;
        int          lat;
        int          busy_cyc;
    } res_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain sum of element products
    function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s = 0;
        for (int i = 0; i < 4; i++) s += 32'(a[8*i +: 8]) * 32'(b[8*i +: 8]);
        return s;
    endfunction

    // Raises start with fresh operands and waits (bounded) for done; returns at the cycle after done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output res_t r);
        @(negedge clk);
        bus.A = a; bus.B = b; bus.start = 1'b1;
        r.lat = 0; r.busy_cyc = 0;
        while (bus.done !== 1'b1 && r.lat < 40) begin
            @(negedge clk);
            r.lat++;
            if (bus.busy === 1'b1) r.busy_cyc++;
        end
        r.dp = bus.dot_product; r.of = bus.oflow; r.rv = bus.result_valid;
        bus.start = 1'b0;
        @(negedge clk);
        r.done_after = bus.done;
    endtask

    task automatic check_op(input string tag, input res_t r, input logic [15:0] dp, input logic of);
        chk({tag, "_latency"}, 32'(r.lat), 32'd6);
        chk({tag, "_dot_product"}, 32'(r.dp), 32'(dp));
        chk({tag, "_oflow"}, 32'(r.of), 32'(of));
        chk({tag, "_result_valid"}, 32'(r.rv), 32'd1);
        chk({tag, "_done_one_cycle"}, 32'(r.done_after), 32'd0);
    endtask

    initial begin
        vec_t tbl[4];
        res_t r;
        int   dones, busy_cyc;
        logic [31:0] s, ra, rb;

        tbl[0] = '{32'h01020304, 32'h01010101, 16'h000A, 1'b0};
        tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 16'hF804, 1'b1};
        tbl[2] = '{32'h000002FF, 32'h0000FFFF, 16'hFFFF, 1'b0};
        tbl[3] = '{32'h000102FF, 32'h0001FFFF, 16'h0000, 1'b1};

        bus.start = 1'b0; bus.A = '0; bus.B = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_rv", 32'(bus.result_valid), 0);
        chk("reset_dp", 32'(bus.dot_product), 0);
        chk("reset_oflow", 32'(bus.oflow), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 0);

        for (int i = 0; i < 4; i++) begin
            run_op(tbl[i].a, tbl[i].b, r);
            check_op($sformatf("tbl%0d", i), r, tbl[i].dp, tbl[i].of);
            chk($sformatf("tbl%0d_busy_len", i), 32'(r.busy_cyc), 32'd5);
        end

        // Start held high for 20 cycles fires once
        @(negedge clk);
        bus.A = 32'h01020304; bus.B = 32'h01010101; bus.start = 1'b1;
        dones = 0;
        repeat (20) begin @(negedge clk); if (bus.done === 1'b1) dones++; end
        chk("held_start_dones", 32'(dones), 1);
        chk("held_start_dp", 32'(bus.dot_product), 32'h000A);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);

        // Second rising edge during busy is ignored
        bus.A = 32'hFFFFFFFF; bus.B = 32'hFFFFFFFF; bus.start = 1'b1;
        dones = 0; busy_cyc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c == 2) begin bus.start = 1'b1; bus.A = 32'h01020304; bus.B = 32'h01010101; end
            if (bus.done === 1'b1) dones++;
            if (bus.busy === 1'b1) busy_cyc++;
        end
        chk("retrigger_dones", 32'(dones), 1);
        chk("retrigger_busy_len", 32'(busy_cyc), 5);
        chk("retrigger_dp", 32'(bus.dot_product), 32'hF804);
        chk("retrigger_oflow", 32'(bus.oflow), 1);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);

        // Operands changed right after capture do not affect the result
        bus.A = 32'h01020304; bus.B = 32'h01010101; bus.start = 1'b1;
        @(negedge clk);
        bus.A = 32'hFFFFFFFF; bus.B = 32'hFFFFFFFF;
        dones = 0;
        repeat (8) begin @(negedge clk); if (bus.done === 1'b1) dones++; end
        chk("capture_dones", 32'(dones), 1);
        chk("capture_dp", 32'(bus.dot_product), 32'h000A);
        chk("capture_oflow", 32'(bus.oflow), 0);
        bus.start = 1'b0;

        // Load nonzero dot_product and oflow, then abort mid-operation with reset
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, r);
        check_op("pre_abort", r, 16'hF804, 1'b1);
        @(negedge clk);
        bus.A = 32'h01020304; bus.B = 32'h01010101; bus.start = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_rv", 32'(bus.result_valid), 0);
        chk("abort_dp", 32'(bus.dot_product), 0);
        chk("abort_oflow", 32'(bus.oflow), 0);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (10) begin @(negedge clk); if (bus.done === 1'b1) dones++; end
        chk("abort_no_done", 32'(dones), 0);
        run_op(32'h01020304, 32'h01010101, r);
        check_op("post_abort", r, 16'h000A, 1'b0);

        // Random operations against the sum model
        for (int i = 0; i < 25; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 3 == 0) begin ra = ra | 32'hF0F0F0F0; rb = rb | 32'hF0F0F0F0; end
            s = model_sum(ra, rb);
            run_op(ra, rb, r);
            check_op($sformatf("rnd%0d", i), r, s[15:0], s >= 32'h10000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
